vip_rgb_ycbcr_csc: RTL
======================

VIP_RGB_YCBCR_CSC -- requirements
Module: vip_rgb_ycbcr_csc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning per-component pixel width (legal range 8..12).
REQ-002 SHALL have parameter CLAMP_EN, default 1, meaning saturate results to [0, 2^DATA_W-1] (0 = plain truncation of the low DATA_W bits).
REQ-003 SHALL have port clk, input, 1, pixel clock; one clock domain only.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports pre_frame_vsync / pre_frame_href / pre_frame_clken, input, 1 each, frame sync, line valid and pixel enable.
REQ-006 SHALL have ports pre_img_red / pre_img_green / pre_img_blue, input, DATA_W each, RGB pixel.
REQ-007 SHALL have port mode_sel, input, 1, colour standard request: 0 = BT.601, 1 = BT.709.
REQ-008 SHALL have port fmt_422, input, 1, output format request: 0 = 4:4:4, 1 = 4:2:2.
REQ-009 SHALL have ports post_frame_vsync / post_frame_href / post_frame_clken, output, 1 each, delayed syncs.
REQ-010 SHALL have ports post_img_Y / post_img_Cb / post_img_Cr, output, DATA_W each, YCbCr pixel.

Function
REQ-011 SHALL use 8-bit fractional coefficients. BT.601: Y(77,150,29), Cb(-43,-85,128), Cr(128,-107,-21). BT.709: Y(54,183,18), Cb(-29,-99,128), Cr(128,-116,-12).
REQ-012 SHALL compute each channel as a signed sum of products at DATA_W+10 bits, with no intermediate overflow.
REQ-013 SHALL add an offset of 2^(DATA_W-1)<<8 to Cb and Cr, add a rounding constant of 128 to all channels, then shift right by 8.
REQ-014 SHALL, when CLAMP_EN=1, clamp negative results to 0 and results at or above 2^DATA_W to 2^DATA_W-1.
REQ-015 SHALL be a free-running 4-stage pipeline, not gated by clken: stage 1 products, stage 2 sums plus offsets, stage 3 round and clamp, stage 4 format mux and output registers.
REQ-016 SHALL delay vsync, href and clken by exactly 4 clocks, aligned with the data.
REQ-017 SHALL drive post_img_Y, post_img_Cb and post_img_Cr to 0 whenever post_frame_href=0.
REQ-018 SHALL detect the rising edge of pre_frame_vsync using a registered copy of vsync (reset 0).
REQ-019 SHALL latch mode_sel and fmt_422 into the active mode registers only on that vsync rising edge; changes at any other time have no effect until the next rising edge.
REQ-020 SHALL carry the active mode registers down the pipeline alongside the data, so a mode change takes effect starting with the first pixel after the edge and never splits a pixel.
REQ-021 SHALL, when active fmt_422=1, output Cb on even pixels and Cr on odd pixels on post_img_Cb, and hold post_img_Cr at 0.
REQ-022 SHALL maintain a 1-bit pixel phase: it advances on each clken=1 & href=1 cycle, clears to 0 (even) whenever href=0, and wraps odd -> even.
REQ-023 SHALL, for pixels within a line, pair the phase with that pixel's data through the pipeline.
REQ-024 SHALL, when active fmt_422=0, output Cb and Cr on their own ports every pixel.
REQ-025 SHALL hold the last active mode if vsync is high when reset releases; the first rising edge after that updates it.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear all pipeline, sync-delay, phase and edge registers.
REQ-027 SHALL, while rst_n=0, hold all outputs at 0.
REQ-028 SHALL set the active mode to BT.601 / 4:4:4 on reset.
REQ-029 SHALL, after rst_n is released, produce valid outputs 4 clocks after the first input; a reset asserted mid-line discards in-flight pixels and emits no partial outputs.

Verification
REQ-030 SHALL cover: DATA_W=8, BT.601, href=1, RGB(255,255,255) -> Y=255, Cb=128, Cr=128 exactly 4 clocks later; RGB(0,0,0) -> Y=0, Cb=128, Cr=128.
REQ-031 SHALL cover: BT.601, RGB(255,0,0) -> Y=77, Cb=85, Cr=255 (unclamped 256 saturates); with CLAMP_EN=0 -> Cr=0.
REQ-032 SHALL cover: mode_sel raised mid-frame -> red still gives Y=77; after the next vsync rising edge, red gives Y=54, Cb=99, Cr=255.
REQ-033 SHALL cover: fmt_422 latched, constant red line of 6 pixels, BT.601 -> post_img_Cb sequence 85,255,85,255,85,255; post_img_Cr=0; href low then high restarts the sequence at 85.
REQ-034 SHALL cover: rst_n pulsed low mid-line -> all outputs 0 immediately; after release, the first post_frame_href=1 appears 4 clocks after input href=1.
REQ-035 SHALL cover: DATA_W=10, BT.601, RGB(1023,1023,1023) -> Y=1023, Cb=512, Cr=512; href=0 with nonzero RGB -> Y/Cb/Cr outputs 0.

Source files
------------

// File: rtl/vip_rgb_ycbcr_csc.sv
// ---------------------------------------------------------------------------
// vip_rgb_ycbcr_csc
// RGB -> YCbCr colour-space converter for a streaming video port.
// Fixed 4-stage pipeline: products, sums + chroma offset, round + clamp,
// then 4:4:4 / 4:2:2 format mux into the output registers.
//
// Ports
//   clk, rst_n                       pixel clock, async active-low reset
//   pre_frame_vsync/href/clken       input frame sync, line valid, pixel enable
//   pre_img_red/green/blue           input RGB pixel, DATA_W bits each
//   mode_sel                         requested standard (0 BT.601, 1 BT.709)
//   fmt_422                          requested output format (0 4:4:4, 1 4:2:2)
//   post_frame_vsync/href/clken      syncs delayed by 4 clocks
//   post_img_Y/Cb/Cr                 output YCbCr pixel, 0 whenever href is low
//
// mode_sel / fmt_422 are only sampled on a vsync rising edge, so a standard
// or format change always lands on a frame boundary.
// ---------------------------------------------------------------------------
module vip_rgb_ycbcr_csc #(
  parameter int DATA_W   = 8,
  parameter bit CLAMP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pre_frame_vsync,
  input  logic              pre_frame_href,
  input  logic              pre_frame_clken,
  input  logic [DATA_W-1:0] pre_img_red,
  input  logic [DATA_W-1:0] pre_img_green,
  input  logic [DATA_W-1:0] pre_img_blue,
  input  logic              mode_sel,
  input  logic              fmt_422,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_Y,
  output logic [DATA_W-1:0] post_img_Cb,
  output logic [DATA_W-1:0] post_img_Cr
);

  // Accumulator width: pixel (DATA_W) x 9-bit signed coefficient, three terms
  // plus chroma offset and rounding stay well inside DATA_W+10 signed bits.
  localparam int ACC_W  = DATA_W + 10;
  localparam int COEF_W = 9;
  localparam int OFS_I  = 1 << (DATA_W + 7);

  localparam logic signed [ACC_W-1:0] CHROMA_OFS = ACC_W'(OFS_I);
  localparam logic signed [ACC_W-1:0] RND        = ACC_W'(128);
  localparam logic signed [ACC_W-1:0] MAX_V      = ACC_W'((1 << DATA_W) - 1);
  localparam logic signed [ACC_W-1:0] ZERO       = '0;

  // Coefficient order: Y(r,g,b), Cb(r,g,b), Cr(r,g,b), scaled by 256.
  localparam logic signed [COEF_W-1:0] K601 [9] = '{
    9'sd77,  9'sd150,  9'sd29,
    -9'sd43, -9'sd85,  9'sd128,
    9'sd128, -9'sd107, -9'sd21
  };
  localparam logic signed [COEF_W-1:0] K709 [9] = '{
    9'sd54,  9'sd183,  9'sd18,
    -9'sd29, -9'sd99,  9'sd128,
    9'sd128, -9'sd116, -9'sd12
  };

  function automatic logic signed [ACC_W-1:0] mul(
    input logic        [DATA_W-1:0] pix,
    input logic signed [COEF_W-1:0] c
  );
    logic signed [ACC_W-1:0] a;
    logic signed [ACC_W-1:0] b;
    a = $signed({{(ACC_W-DATA_W){1'b0}}, pix});
    b = {{(ACC_W-COEF_W){c[COEF_W-1]}}, c};
    return a * b;
  endfunction

  // Round to nearest (add half LSB, arithmetic shift) then either saturate
  // into the pixel range or keep the low DATA_W bits.
  function automatic logic [DATA_W-1:0] round_sat(
    input logic signed [ACC_W-1:0] acc
  );
    logic signed [ACC_W-1:0] q;
    q = (acc + RND) >>> 8;
    if (CLAMP_EN && (q < ZERO)) return '0;
    if (CLAMP_EN && (q > MAX_V)) return '1;
    return q[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] rgb [3];
  assign rgb[0] = pre_img_red;
  assign rgb[1] = pre_img_green;
  assign rgb[2] = pre_img_blue;

  // Mode control and pixel phase
  logic vsync_d;
  logic vs_arm;
  logic mode_act;
  logic fmt_act;
  logic ph;
  logic vs_rise;

  // vs_arm only sets once vsync has been seen low, so a vsync that is already
  // high when reset releases is not mistaken for a new frame.
  assign vs_rise = pre_frame_vsync & ~vsync_d & vs_arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d  <= 1'b0;
      vs_arm   <= 1'b0;
      mode_act <= 1'b0;
      fmt_act  <= 1'b0;
      ph       <= 1'b0;
    end else begin
      vsync_d <= pre_frame_vsync;
      vs_arm  <= vs_arm | ~pre_frame_vsync;
      if (vs_rise) begin
        mode_act <= mode_sel;
        fmt_act  <= fmt_422;
      end
      if (!pre_frame_href)
        ph <= 1'b0;
      else if (pre_frame_clken)
        ph <= ~ph;
    end
  end

  // Stage 1: nine coefficient products
  logic signed [ACC_W-1:0] prod_p1 [9];
  logic vsync_p1, href_p1, vld_p1, fmt_p1, ph_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) prod_p1[i] <= '0;
      vsync_p1 <= 1'b0;
      href_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      fmt_p1   <= 1'b0;
      ph_p1    <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++)
        prod_p1[i] <= mul(rgb[i % 3], mode_act ? K709[i] : K601[i]);
      vsync_p1 <= pre_frame_vsync;
      href_p1  <= pre_frame_href;
      vld_p1   <= pre_frame_clken;
      fmt_p1   <= fmt_act;
      ph_p1    <= ph;
    end
  end

  // Stage 2: channel sums, chroma offset
  logic signed [ACC_W-1:0] y_p2, cb_p2, cr_p2;
  logic vsync_p2, href_p2, vld_p2, fmt_p2, ph_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p2     <= '0;
      cb_p2    <= '0;
      cr_p2    <= '0;
      vsync_p2 <= 1'b0;
      href_p2  <= 1'b0;
      vld_p2   <= 1'b0;
      fmt_p2   <= 1'b0;
      ph_p2    <= 1'b0;
    end else begin
      y_p2     <= prod_p1[0] + prod_p1[1] + prod_p1[2];
      cb_p2    <= prod_p1[3] + prod_p1[4] + prod_p1[5] + CHROMA_OFS;
      cr_p2    <= prod_p1[6] + prod_p1[7] + prod_p1[8] + CHROMA_OFS;
      vsync_p2 <= vsync_p1;
      href_p2  <= href_p1;
      vld_p2   <= vld_p1;
      fmt_p2   <= fmt_p1;
      ph_p2    <= ph_p1;
    end
  end

  // Stage 3: round and clamp
  logic [DATA_W-1:0] y_p3, cb_p3, cr_p3;
  logic vsync_p3, href_p3, vld_p3, fmt_p3, ph_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p3     <= '0;
      cb_p3    <= '0;
      cr_p3    <= '0;
      vsync_p3 <= 1'b0;
      href_p3  <= 1'b0;
      vld_p3   <= 1'b0;
      fmt_p3   <= 1'b0;
      ph_p3    <= 1'b0;
    end else begin
      y_p3     <= round_sat(y_p2);
      cb_p3    <= round_sat(cb_p2);
      cr_p3    <= round_sat(cr_p2);
      vsync_p3 <= vsync_p2;
      href_p3  <= href_p2;
      vld_p3   <= vld_p2;
      fmt_p3   <= fmt_p2;
      ph_p3    <= ph_p2;
    end
  end

  // Stage 4: format mux, blanking, output registers
  logic [DATA_W-1:0] y_p4, cb_p4, cr_p4;
  logic vsync_p4, href_p4, vld_p4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p4     <= '0;
      cb_p4    <= '0;
      cr_p4    <= '0;
      vsync_p4 <= 1'b0;
      href_p4  <= 1'b0;
      vld_p4   <= 1'b0;
    end else begin
      vsync_p4 <= vsync_p3;
      href_p4  <= href_p3;
      vld_p4   <= vld_p3;
      if (!href_p3) begin
        y_p4  <= '0;
        cb_p4 <= '0;
        cr_p4 <= '0;
      end else if (fmt_p3) begin
        // 4:2:2: chroma is time-multiplexed on the Cb port, Cb on even pixels
        y_p4  <= y_p3;
        cb_p4 <= ph_p3 ? cr_p3 : cb_p3;
        cr_p4 <= '0;
      end else begin
        y_p4  <= y_p3;
        cb_p4 <= cb_p3;
        cr_p4 <= cr_p3;
      end
    end
  end

  assign post_frame_vsync = vsync_p4;
  assign post_frame_href  = href_p4;
  assign post_frame_clken = vld_p4;
  assign post_img_Y       = y_p4;
  assign post_img_Cb      = cb_p4;
  assign post_img_Cr      = cr_p4;

endmodule
